mem_seq_ctrl: RTL and testbench
===============================

# mem_seq_ctrl

Sequencing controller for the register file's data-memory path and write port. It runs load and store transfers between DMAR/DMDR (regs 0/1) and the data memory with a fixed memory latency. It also arbitrates the register file's C-bus write port between control-unit writebacks and the memory-load capture, stalling writebacks that would conflict. It sits between the control unit, the register file (drives its `C_EN`, `C_SEL` and `MEM_READ`) and the data memory (drives its `dm_re` and `dm_we`).

## Interface
Parameters:
- `MEM_LAT`, default 2: cycles from memory request to valid read data or write completion; legal range 1..15.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `ld_req`  in  1  load request from the control unit: memory[DMAR] -> DMDR.
- `st_req`  in  1  store request from the control unit: DMDR -> memory[DMAR].
- `wb_en`  in  1  control-unit writeback request.
- `wb_sel`  in  4  writeback destination register index (0..13).
- `busy`  out  1  a transfer is in progress.
- `done`  out  1  one-cycle pulse when a transfer completes.
- `wb_stall`  out  1  the writeback is not performed this cycle; the control unit holds `wb_en`/`wb_sel`.
- `C_EN`  out  1  register-file C-bus write enable.
- `C_SEL`  out  4  register-file C-bus destination.
- `MEM_READ`  out  2  2'b11 = register file captures `mem_data` into DMDR; otherwise 2'b00.
- `dm_re`  out  1  data-memory read enable.
- `dm_we`  out  1  data-memory write enable.

## Operation
- FSM states: IDLE, RD_WAIT, RD_LATCH, WR_WAIT, DONE. A 4-bit down-counter `cnt` times the memory latency.
- IDLE:
  - `ld_req`=1 -> RD_WAIT, `cnt`=MEM_LAT-1.
  - Otherwise `st_req`=1 -> WR_WAIT, `cnt`=MEM_LAT-1.
  - If both are high, the load wins and the store is dropped; the control unit must re-request it.
- RD_WAIT: `dm_re`=1. When `cnt`=0 -> RD_LATCH; otherwise decrement `cnt`.
- RD_LATCH: `MEM_READ`=2'b11, `dm_re`=0. Next state is DONE.
- WR_WAIT: `dm_we`=1. When `cnt`=0 -> DONE; otherwise decrement `cnt`.
- DONE: `done`=1. Next state is IDLE.
- Requests are sampled only in IDLE. `ld_req`/`st_req` in any other state, including DONE, are ignored.
- `busy` = 1 in RD_WAIT, RD_LATCH and WR_WAIT.
- `dm_re`, `dm_we`, `MEM_READ`, `busy` and `done` are decoded from the registered state only; there is no input-to-output path.
- Writeback arbitration (combinational):
  - `wb_stall` = `wb_en` & ~`RST` & (state==RD_LATCH | (`busy` & `wb_sel`<=1)).
  - This blocks every writeback during the DMDR capture cycle. It also blocks writes to DMAR/DMDR for the whole transfer, so the address and data stay stable.
  - `C_EN` = `wb_en` & ~`wb_stall` & ~`RST` & (`wb_sel`<=13).
  - `wb_sel` of 14 or 15 gives `C_EN`=0 with no stall; the write is discarded.
  - `C_SEL` = `wb_sel` (pass-through).
- Writebacks to regs 2..13 proceed during RD_WAIT and WR_WAIT.
- Reset: the state goes to IDLE and `cnt` to 0 on the first clock edge with `RST` high.
  - Reset values: `busy`, `done`, `dm_re`, `dm_we` = 0; `MEM_READ` = 2'b00.
  - `C_EN` and `wb_stall` are forced 0 combinationally while `RST` is high.
- Reset mid-transfer: the transfer is aborted, no `done` pulse is produced, and DMDR is not captured.

## Timing
- Load, with `ld_req` high in IDLE at cycle 0:
  - `dm_re` = 1 in cycles 1..MEM_LAT.
  - `MEM_READ` = 2'b11 in cycle MEM_LAT+1; DMDR is written at the end of that cycle.
  - `done` = 1 in cycle MEM_LAT+2.
  - IDLE in cycle MEM_LAT+3, so the earliest next request is sampled in that cycle.
  - `busy` = 1 in cycles 1..MEM_LAT+1.
- Store, with `st_req` at cycle 0:
  - `dm_we` = 1 in cycles 1..MEM_LAT.
  - `done` = 1 in cycle MEM_LAT+1.
  - IDLE in cycle MEM_LAT+2.
  - `busy` = 1 in cycles 1..MEM_LAT.
- MEM_LAT=1 boundary: RD_WAIT and WR_WAIT each last exactly one cycle.
- Writeback pass-through has zero latency: `C_EN` and `C_SEL` are valid in the same cycle as `wb_en`.
- A stalled writeback completes in the first cycle the stall condition clears.

## Test plan
- Load, MEM_LAT=2, `ld_req` pulse at cycle 0 -> `dm_re` high in cycles 1–2; `MEM_READ`=2'b11 in cycle 3; `done` in cycle 4; `busy` high in cycles 1–3; IDLE in cycle 5.
- Store, MEM_LAT=1, `st_req` at cycle 0 -> `dm_we` high in cycle 1 only; `done` in cycle 2; `dm_re`=0 throughout.
- `ld_req`=`st_req`=1 together -> load sequence only; `dm_we` never asserts; a second `st_req` issued in cycle MEM_LAT+3 starts a store.
- Writeback during a load:
  - `wb_en` with `wb_sel`=5 in cycle 1 -> `C_EN`=1, `C_SEL`=5.
  - `wb_sel`=5 held in RD_LATCH -> `wb_stall`=1, `C_EN`=0; completes in the DONE cycle.
  - `wb_sel`=0 during `busy` -> stalled until DONE.
- `wb_en` with `wb_sel`=14 in IDLE -> `C_EN`=0, `wb_stall`=0.
- `RST` asserted in cycle 2 of a MEM_LAT=4 load -> `dm_re`=0 from cycle 3; `MEM_READ` stays 2'b00; no `done`; a new `ld_req` after reset completes normally.

Source files
------------

// File: rtl/mem_seq_ctrl.sv
// Data-memory load/store sequencer and register-file C-bus write arbiter.
// Latency: load MEM_LAT+2 cycles to done, store MEM_LAT+1; writeback pass-through is zero-latency.
// Backpressure: requests are accepted only in IDLE; conflicting writebacks are held off via wb_stall.
module mem_seq_ctrl #(
    parameter int unsigned MEM_LAT = 2     // legal range 1..15
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       ld_req,
    input  logic       st_req,
    input  logic       wb_en,
    input  logic [3:0] wb_sel,
    output logic       busy,
    output logic       done,
    output logic       wb_stall,
    output logic       C_EN,
    output logic [3:0] C_SEL,
    output logic [1:0] MEM_READ,
    output logic       dm_re,
    output logic       dm_we
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_LATCH = 3'd2,
        WR_WAIT  = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Counter reload: the wait state lasts cnt+1 cycles, so start at MEM_LAT-1.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    // State and latency counter registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; memory-side outputs are decoded from the registered state only.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        done      = 1'b0;
        dm_re     = 1'b0;
        dm_we     = 1'b0;
        MEM_READ  = 2'b00;
        case (state)
            IDLE: begin
                // Load has priority; a simultaneous store is dropped.
                if (ld_req) begin
                    state_nxt = RD_WAIT;
                    cnt_nxt   = CNT_INIT;
                end else if (st_req) begin
                    state_nxt = WR_WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            RD_WAIT: begin
                busy  = 1'b1;
                dm_re = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = RD_LATCH;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RD_LATCH: begin
                busy      = 1'b1;
                MEM_READ  = 2'b11;
                state_nxt = DONE;
            end
            WR_WAIT: begin
                busy  = 1'b1;
                dm_we = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // C-bus arbitration: the DMDR capture cycle owns the port, and DMAR/DMDR are
    // write-protected for the whole transfer so address and data stay stable.
    always_comb begin
        wb_stall = wb_en & ~RST & ((state == RD_LATCH) | (busy & (wb_sel <= 4'd1)));
        C_EN     = wb_en & ~wb_stall & ~RST & (wb_sel <= 4'd13);
        C_SEL    = wb_sel;
    end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl at MEM_LAT = 2, 1 and 4.
// Each cycle's expected outputs are queued when the stimulus is driven and
// popped and compared on the following falling edge.
module tb_mem_seq_ctrl;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       re;
        logic       we;
        logic [1:0] mr;
        logic       cen;
        logic [3:0] csel;
        logic       stall;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v, ld_v, st_v, wbe_v;
    logic [3:0] wbs_v  [3];
    logic [2:0] busy_v, done_v, re_v, we_v, cen_v, stall_v;
    logic [1:0] mr_v   [3];
    logic [3:0] csel_v [3];

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    mem_seq_ctrl #(.MEM_LAT(2)) u_lat2 (
        .clk(clk), .RST(rst_v[0]), .ld_req(ld_v[0]), .st_req(st_v[0]),
        .wb_en(wbe_v[0]), .wb_sel(wbs_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .wb_stall(stall_v[0]), .C_EN(cen_v[0]), .C_SEL(csel_v[0]),
        .MEM_READ(mr_v[0]), .dm_re(re_v[0]), .dm_we(we_v[0])
    );

    mem_seq_ctrl #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .RST(rst_v[1]), .ld_req(ld_v[1]), .st_req(st_v[1]),
        .wb_en(wbe_v[1]), .wb_sel(wbs_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .wb_stall(stall_v[1]), .C_EN(cen_v[1]), .C_SEL(csel_v[1]),
        .MEM_READ(mr_v[1]), .dm_re(re_v[1]), .dm_we(we_v[1])
    );

    mem_seq_ctrl #(.MEM_LAT(4)) u_lat4 (
        .clk(clk), .RST(rst_v[2]), .ld_req(ld_v[2]), .st_req(st_v[2]),
        .wb_en(wbe_v[2]), .wb_sel(wbs_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .wb_stall(stall_v[2]), .C_EN(cen_v[2]), .C_SEL(csel_v[2]),
        .MEM_READ(mr_v[2]), .dm_re(re_v[2]), .dm_we(we_v[2])
    );

    // Load issued at cycle 0: dm_re 1..L, MEM_READ at L+1, done at L+2, busy 1..L+1.
    function automatic exp_t load_exp(int lat, int c);
        exp_t e = '0;
        e.busy = (c >= 1 && c <= lat + 1);
        e.re   = (c >= 1 && c <= lat);
        e.mr   = (c == lat + 1) ? 2'b11 : 2'b00;
        e.done = (c == lat + 2);
        return e;
    endfunction

    // Store issued at cycle 0: dm_we 1..L, done at L+1, busy 1..L.
    function automatic exp_t store_exp(int lat, int c);
        exp_t e = '0;
        e.busy = (c >= 1 && c <= lat);
        e.we   = (c >= 1 && c <= lat);
        e.done = (c == lat + 1);
        return e;
    endfunction

    function automatic exp_t with_wb(exp_t e, logic cen, logic [3:0] csel, logic stall);
        exp_t r = e;
        r.cen   = cen;
        r.csel  = csel;
        r.stall = stall;
        return r;
    endfunction

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
    task automatic cyc(int inst, logic rst, logic ld, logic st, logic wbe,
                       logic [3:0] wbs, exp_t e, string tag);
        exp_t g;
        rst_v[inst] = rst;
        ld_v[inst]  = ld;
        st_v[inst]  = st;
        wbe_v[inst] = wbe;
        wbs_v[inst] = wbs;
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        chk({tag, " busy"},     {3'b0, busy_v[inst]},  {3'b0, g.busy});
        chk({tag, " done"},     {3'b0, done_v[inst]},  {3'b0, g.done});
        chk({tag, " dm_re"},    {3'b0, re_v[inst]},    {3'b0, g.re});
        chk({tag, " dm_we"},    {3'b0, we_v[inst]},    {3'b0, g.we});
        chk({tag, " MEM_READ"}, {2'b0, mr_v[inst]},    {2'b0, g.mr});
        chk({tag, " C_EN"},     {3'b0, cen_v[inst]},   {3'b0, g.cen});
        chk({tag, " C_SEL"},    csel_v[inst],          g.csel);
        chk({tag, " wb_stall"}, {3'b0, stall_v[inst]}, {3'b0, g.stall});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_v = '1;
        ld_v  = '0;
        st_v  = '0;
        wbe_v = '0;
        for (int i = 0; i < 3; i++) wbs_v[i] = 4'd0;
        @(posedge clk);
        #1;

        // Reset state, with C_EN / wb_stall forced low while RST is high.
        for (int i = 0; i < 3; i++) begin
            cyc(i, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, '0, $sformatf("rst%0d sel0", i));
            cyc(i, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, with_wb('0, 1'b0, 4'd7, 1'b0),
                $sformatf("rst%0d sel7", i));
        end
        for (int i = 0; i < 3; i++) cyc(i, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, '0, "idle");

        // Load, MEM_LAT=2.
        for (int c = 0; c <= 5; c++)
            cyc(0, 1'b0, c == 0, 1'b0, 1'b0, 4'd0, load_exp(2, c), $sformatf("ld2 c%0d", c));

        // Store, MEM_LAT=1.
        for (int c = 0; c <= 3; c++)
            cyc(1, 1'b0, 1'b0, c == 0, 1'b0, 4'd0, store_exp(1, c), $sformatf("st1 c%0d", c));

        // Load and store together: load wins; store held high is taken at cycle L+3.
        for (int c = 0; c <= 9; c++)
            cyc(0, 1'b0, c == 0, c <= 5, 1'b0, 4'd0,
                (c <= 4) ? load_exp(2, c) : store_exp(2, c - 5), $sformatf("ldst c%0d", c));

        // Writebacks during a load: regs 5/13 pass in RD_WAIT, everything stalls in RD_LATCH.
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  load_exp(2, 0), "wbA c0");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  with_wb(load_exp(2, 1), 1'b1, 4'd5,  1'b0), "wbA c1");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd13, with_wb(load_exp(2, 2), 1'b1, 4'd13, 1'b0), "wbA c2");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  with_wb(load_exp(2, 3), 1'b0, 4'd5,  1'b1), "wbA c3");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  with_wb(load_exp(2, 4), 1'b1, 4'd5,  1'b0), "wbA c4");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  '0, "wbA c5");

        // Writes to DMAR/DMDR are held off for the whole load and complete in DONE.
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, load_exp(2, 0), "wbB c0");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, with_wb(load_exp(2, 1), 1'b0, 4'd1, 1'b1), "wbB c1");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, with_wb(load_exp(2, 2), 1'b0, 4'd0, 1'b1), "wbB c2");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, with_wb(load_exp(2, 3), 1'b0, 4'd0, 1'b1), "wbB c3");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, with_wb(load_exp(2, 4), 1'b1, 4'd0, 1'b0), "wbB c4");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, '0, "wbB c5");

        // Writebacks during a store: reg 2 proceeds, reg 1 stalls until DONE.
        cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, store_exp(2, 0), "wbC c0");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, with_wb(store_exp(2, 1), 1'b1, 4'd2, 1'b0), "wbC c1");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, with_wb(store_exp(2, 2), 1'b0, 4'd1, 1'b1), "wbC c2");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, with_wb(store_exp(2, 3), 1'b1, 4'd1, 1'b0), "wbC c3");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, '0, "wbC c4");

        // Out-of-range destinations are discarded without a stall.
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd14, with_wb('0, 1'b0, 4'd14, 1'b0), "wb14");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, with_wb('0, 1'b0, 4'd15, 1'b0), "wb15");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  with_wb('0, 1'b1, 4'd3,  1'b0), "wb3");
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  '0, "wb idle");

        // Reset in cycle 2 of a MEM_LAT=4 load aborts it; a fresh load then completes.
        cyc(2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, load_exp(4, 0), "rstld c0");
        cyc(2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, load_exp(4, 1), "rstld c1");
        cyc(2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, with_wb(load_exp(4, 2), 1'b0, 4'd5, 1'b0), "rstld c2");
        for (int c = 3; c <= 8; c++)
            cyc(2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, '0, $sformatf("rstld c%0d", c));
        for (int c = 0; c <= 7; c++)
            cyc(2, 1'b0, c == 0, 1'b0, 1'b0, 4'd0, load_exp(4, c), $sformatf("ld4 c%0d", c));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
